// File: rtl/fifo_word_packer.sv
// Pops bytes from a 1-cycle-latency byte FIFO and packs them little-endian into words
// presented on a valid/ready handshake; FLUSH emits a zero-padded partial word.
module fifo_word_packer #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned CNT_W          = 4
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_fifo_empty,
    input  logic [DATA_W-1:0]                i_fifo_dout,
    output logic                             o_fifo_rd_en,
    input  logic                             i_flush,
    output logic [DATA_W*BYTES_PER_WORD-1:0] o_word_out,
    output logic [CNT_W-1:0]                 o_word_bytes,
    output logic                             o_word_valid,
    input  logic                             i_word_ready
);

    typedef enum logic [0:0] {StFill, StHold} state_e;

    localparam logic [CNT_W-1:0] BPW_CNT = CNT_W'(BYTES_PER_WORD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                                  r_state;
    logic [CNT_W-1:0]                        r_issued;
    logic [CNT_W-1:0]                        r_captured;
    logic                                    r_pending;
    logic                                    r_flush;
    logic                                    r_rst_dly;
    logic [BYTES_PER_WORD-1:0][DATA_W-1:0]   r_lanes;

    state_e                                  w_state_nxt;
    logic [CNT_W-1:0]                        w_issued_nxt;
    logic [CNT_W-1:0]                        w_captured_nxt;
    logic                                    w_flush_nxt;
    logic [BYTES_PER_WORD-1:0][DATA_W-1:0]   w_lanes_nxt;
    logic                                    w_rd_en;
    logic                                    w_hold;

    // r_rst_dly keeps reads off for the first cycle after reset release.
    assign w_rd_en = (r_state == StFill) && !i_fifo_empty && (r_issued < BPW_CNT) &&
                     !r_flush && !r_rst_dly && !i_rst;

    always_comb begin
        w_state_nxt    = r_state;
        w_issued_nxt   = r_issued;
        w_captured_nxt = r_captured;
        w_flush_nxt    = r_flush;
        w_lanes_nxt    = r_lanes;

        unique case (r_state)
            StFill: begin
                if (w_rd_en) begin
                    w_issued_nxt = r_issued + CNT_ONE;
                end
                if (r_pending) begin
                    for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
                        if (r_captured == CNT_W'(i)) begin
                            w_lanes_nxt[i] = i_fifo_dout;
                        end
                    end
                    w_captured_nxt = r_captured + CNT_ONE;
                end
                if (i_flush && ((r_captured != '0) || r_pending)) begin
                    w_flush_nxt = 1'b1;
                end
                // A flushed word waits for its in-flight byte before being presented.
                if ((w_captured_nxt == BPW_CNT) || (r_flush && !r_pending)) begin
                    w_state_nxt = StHold;
                end
            end
            StHold: begin
                if (i_word_ready) begin
                    w_state_nxt    = StFill;
                    w_issued_nxt   = '0;
                    w_captured_nxt = '0;
                    w_flush_nxt    = 1'b0;
                    w_lanes_nxt    = '0;
                end
            end
            default: begin
                w_state_nxt = StFill;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        r_rst_dly <= i_rst;
        if (i_rst) begin
            r_state    <= StFill;
            r_issued   <= '0;
            r_captured <= '0;
            r_pending  <= 1'b0;
            r_flush    <= 1'b0;
            r_lanes    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_issued   <= w_issued_nxt;
            r_captured <= w_captured_nxt;
            r_pending  <= w_rd_en;
            r_flush    <= w_flush_nxt;
            r_lanes    <= w_lanes_nxt;
        end
    end

    assign w_hold       = (r_state == StHold) && !i_rst;
    assign o_fifo_rd_en = w_rd_en;
    assign o_word_valid = w_hold;
    assign o_word_bytes = w_hold ? r_captured : '0;
    assign o_word_out   = i_rst ? '0 : r_lanes;

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed and randomized checks of fifo_word_packer against a queue-based FIFO and a
// byte-stream reference model.
module tb_fifo_word_packer;

    localparam int DW  = 8;
    localparam int BPW = 4;
    localparam int CW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            fifo_empty;
    logic [DW-1:0]   fifo_dout;
    logic            rd_en;
    logic            flush;
    logic [DW*BPW-1:0] word_out;
    logic [CW-1:0]   word_bytes;
    logic            word_valid;
    logic            word_ready;

    always #5 clk = ~clk;

    fifo_word_packer #(
        .DATA_W        (DW),
        .BYTES_PER_WORD(BPW),
        .CNT_W         (CW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_fifo_empty(fifo_empty),
        .i_fifo_dout (fifo_dout),
        .o_fifo_rd_en(rd_en),
        .i_flush     (flush),
        .o_word_out  (word_out),
        .o_word_bytes(word_bytes),
        .o_word_valid(word_valid),
        .i_word_ready(word_ready)
    );

    logic [7:0] q[$];
    logic [7:0] acc[$];
    logic [7:0] emitted[$];
    logic [7:0] pushed[$];

    int n_vec = 0;
    int n_err = 0;
    int n_rd  = 0;
    bit flush_armed = 1'b0;

    logic        s_rd;
    logic        s_valid;
    logic [31:0] s_word;
    logic [3:0]  s_bytes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] acc_word();
        logic [31:0] w = '0;
        for (int i = 0; i < acc.size() && i < BPW; i++) w[8*i +: 8] = acc[i];
        return w;
    endfunction

    task automatic push(input logic [7:0] b);
        q.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: sample at negedge, model the FIFO and handshake just after posedge.
    task automatic cycle();
        bit rd;
        bit hs;
        @(negedge clk);
        s_rd    = rd_en;
        s_valid = word_valid;
        s_word  = word_out;
        s_bytes = word_bytes;
        chk("rd_while_empty", 32'(s_rd & fifo_empty), 32'd0);
        if (s_valid) begin
            chk("model_word", s_word, acc_word());
            chk("model_bytes", 32'(s_bytes), 32'(acc.size()));
            chk("rd_in_hold", 32'(s_rd), 32'd0);
            if (!flush_armed) chk("full_count", 32'(acc.size()), 32'(BPW));
        end
        if (!rst && !s_valid && flush && acc.size() > 0) flush_armed = 1'b1;
        rd = s_rd && !fifo_empty;
        hs = s_valid && word_ready && !rst;
        @(posedge clk);
        #1;
        if (rst) begin
            acc.delete();
            flush_armed = 1'b0;
        end else if (hs) begin
            for (int i = 0; i < BPW && i < int'(s_bytes); i++) emitted.push_back(s_word[8*i +: 8]);
            acc.delete();
            flush_armed = 1'b0;
        end
        if (rd) begin
            fifo_dout = q.pop_front();
            acc.push_back(fifo_dout);
            n_rd++;
        end
        fifo_empty = (q.size() == 0);
    endtask

    task automatic wait_word(input string tag, output logic [31:0] w, output logic [3:0] nb);
        bit ok = 1'b0;
        w  = '0;
        nb = '0;
        for (int k = 0; k < 40 && !ok; k++) begin
            cycle();
            if (s_valid) begin
                ok = 1'b1;
                w  = s_word;
                nb = s_bytes;
            end
        end
        chk({tag, "_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] w;
        logic [3:0]  nb;
        int          nv;
        int          rd0;
        bit          done;

        rst        = 1'b1;
        fifo_empty = 1'b1;
        fifo_dout  = '0;
        flush      = 1'b0;
        word_ready = 1'b0;

        // Reset with a non-empty FIFO, then a full word.
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("rst_rd", 32'(s_rd), 32'd0);
            chk("rst_valid", 32'(s_valid), 32'd0);
            chk("rst_word", s_word, 32'd0);
            chk("rst_bytes", 32'(s_bytes), 32'd0);
        end
        rst        = 1'b0;
        word_ready = 1'b1;
        cycle();
        chk("rel_rd", 32'(s_rd), 32'd0);
        chk("rel_valid", 32'(s_valid), 32'd0);
        chk("rel_word", s_word, 32'd0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("burst_rd", 32'(s_rd), 32'd1);
        end
        cycle();
        chk("burst_rd_end", 32'(s_rd), 32'd0);
        chk("burst_valid_early", 32'(s_valid), 32'd0);
        cycle();
        chk("full_valid", 32'(s_valid), 32'd1);
        chk("full_word", s_word, 32'h04030201);
        chk("full_bytes", 32'(s_bytes), 32'd4);
        cycle();
        chk("full_valid_drop", 32'(s_valid), 32'd0);

        // Backpressure.
        word_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
        wait_word("bp1", w, nb);
        chk("bp1_word", w, 32'h13121110);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_valid", 32'(s_valid), 32'd1);
            chk("bp_word", s_word, 32'h13121110);
            chk("bp_rd", 32'(s_rd), 32'd0);
        end
        word_ready = 1'b1;
        cycle();
        wait_word("bp2", w, nb);
        chk("bp2_word", w, 32'h17161514);
        chk("bp2_bytes", 32'(nb), 32'd4);

        // Partial flush, then an empty flush.
        push(8'hAA); push(8'hBB); push(8'hCC);
        nv = 0;
        repeat (6) begin
            cycle();
            nv += int'(s_valid);
        end
        chk("pf_no_early_word", 32'(nv), 32'd0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wait_word("pf", w, nb);
        chk("pf_word", w, 32'h00CCBBAA);
        chk("pf_bytes", 32'(nb), 32'd3);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        nv = 0;
        repeat (8) begin
            cycle();
            nv += int'(s_valid);
        end
        chk("empty_flush_no_word", 32'(nv), 32'd0);

        // Flush on the cycle of the second read.
        push(8'h55); push(8'h66); push(8'h77);
        cycle();
        chk("if_rd1", 32'(s_rd), 32'd1);
        flush = 1'b1;
        cycle();
        chk("if_rd2", 32'(s_rd), 32'd1);
        flush = 1'b0;
        rd0 = n_rd;
        wait_word("if", w, nb);
        chk("if_word", w, 32'h00006655);
        chk("if_bytes", 32'(nb), 32'd2);
        chk("if_no_third_read", 32'(n_rd - rd0), 32'd0);
        repeat (3) cycle();
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        wait_word("if_tail", w, nb);
        chk("if_tail_word", w, 32'h00000077);
        chk("if_tail_bytes", 32'(nb), 32'd1);

        // FIFO runs dry mid-word.
        push(8'h11); push(8'h22);
        nv = 0;
        repeat (6) begin
            cycle();
            nv += int'(s_valid);
        end
        chk("uf_no_word", 32'(nv), 32'd0);
        push(8'h33); push(8'h44);
        wait_word("uf", w, nb);
        chk("uf_word", w, 32'h44332211);
        chk("uf_bytes", 32'(nb), 32'd4);

        // Reset after two captured bytes.
        push(8'h99); push(8'h98);
        repeat (4) cycle();
        rst = 1'b1;
        q.delete();
        fifo_empty = 1'b1;
        repeat (2) begin
            cycle();
            chk("mr_valid", 32'(s_valid), 32'd0);
        end
        rst = 1'b0;
        cycle();
        chk("mr_rel_valid", 32'(s_valid), 32'd0);
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        wait_word("mr", w, nb);
        chk("mr_word", w, 32'h04030201);
        chk("mr_bytes", 32'(nb), 32'd4);

        // Randomized traffic: every pushed byte must come out once, in order.
        emitted.delete();
        pushed.delete();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 60) begin
                logic [7:0] b;
                b = 8'($urandom);
                push(b);
                pushed.push_back(b);
            end
            word_ready = 1'($urandom_range(0, 1));
            flush      = ($urandom_range(0, 99) < 6);
            cycle();
            flush = 1'b0;
        end
        word_ready = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            flush = (k % 8 == 0);
            cycle();
            flush = 1'b0;
            done = (q.size() == 0) && (acc.size() == 0) && !s_valid;
        end
        chk("rnd_drained", 32'(done), 32'd1);
        chk("rnd_stream_len", 32'(emitted.size()), 32'(pushed.size()));
        for (int i = 0; i < pushed.size() && i < emitted.size(); i++) begin
            chk("rnd_stream_byte", 32'(emitted[i]), 32'(pushed[i]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
